dac_stream_source: RTL and testbench

Table-driven AXI4-Stream sample source that generates the 256-bit multi-lane DAC word consumed by `dac_top` on its `s_axis_*` port. It plays back one period of a stored waveform on each enabled DAC lane in turn, driving the active lane and zeroing all others. It is the on-chip transmitter for channel-sweep bring-up, and replaces bench-side stimulus in system builds.

---
 rtl/dac_stream_source.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_dac_stream_source.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_stream_source.sv
// dac_stream_source
//   Table-driven AXI4-Stream sample source. Plays one period of the stored
//   waveform on each enabled DAC lane in ascending lane order, driving the
//   active lane and zeroing all other lanes of the output word.
//
//   Optional feature macro: DAC_SRC_GAIN_EN
//     defined   : adds the `gain` port (Q2.14 signed) and one extra pipeline
//                 stage that scales and saturates every emitted sample.
//     undefined : samples pass through unchanged; no multiplier, no stage.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   tbl_we/addr/wdata waveform table write port (ignored while busy)
//   num_samples      samples per lane period, clamped to DEPTH, latched on start
//   ch_mask          enabled lanes, latched on start
//   gain             Q2.14 gain, latched on start (DAC_SRC_GAIN_EN only)
//   start            single-cycle sweep request, honoured only in IDLE
//   m_axis_*         AXI4-Stream master (tdata/tvalid/tready/tlast)
//   active_ch        lane carried by the current output beat
//   busy             sweep in progress
//   done             one-cycle pulse after the final beat was accepted
module dac_stream_source #(
  parameter  int unsigned N_DAC    = 16,
  parameter  int unsigned DAC_BITS = 16,
  parameter  int unsigned DEPTH    = 256,
  localparam int unsigned BITS     = N_DAC * DAC_BITS,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned CW       = $clog2(N_DAC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tbl_we,
  input  logic [AW-1:0]       tbl_addr,
  input  logic [DAC_BITS-1:0] tbl_wdata,
  input  logic [AW:0]         num_samples,
  input  logic [N_DAC-1:0]    ch_mask,
`ifdef DAC_SRC_GAIN_EN
  input  logic [15:0]         gain,
`endif
  input  logic                start,
  output logic [BITS-1:0]     m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [CW-1:0]       active_ch,
  output logic                busy,
  output logic                done
);

  localparam int unsigned NW = AW + 1;
`ifdef DAC_SRC_GAIN_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif
  // Skid holds every beat that can be in flight when the output stalls.
  localparam int unsigned SK  = LAT;
  localparam int unsigned SKW = 2;
  localparam int unsigned OW  = 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [DAC_BITS-1:0] data;
    logic [CW-1:0]       ch;
    logic                last;
  } beat_t;

  state_t            state_q, state_d;
  logic [N_DAC-1:0]  mask_q, mask_d;
  logic [NW-1:0]     num_q, num_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [CW:0]       lo, nx;
  logic              issue, issue_last, accept, room;

  logic [DAC_BITS-1:0] mem [DEPTH];
  logic [DAC_BITS-1:0] ram_q;
  logic                r_v, r_last;
  logic [CW-1:0]       r_ch;

  beat_t             land, out_pl;
  logic              land_v;
  beat_t             skid [SK];
  logic [SKW-1:0]    sk_cnt;
  logic              out_free, pop, push, load;
  int                push_idx;

  // Lowest set mask bit at or above lane `from`; MSB flags that one exists.
  function automatic logic [CW:0] first_set(input logic [N_DAC-1:0] m, input int from);
    logic [CW:0] r;
    r = '0;
    for (int i = int'(N_DAC) - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, CW'(i)};
    end
    return r;
  endfunction

  // Sweep sequencer: next state, counters and read issue.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    num_d      = num_q;
    idx_d      = idx_q;
    ch_d       = ch_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    lo         = first_set(ch_mask, 0);
    nx         = first_set(mask_q, int'(ch_q) + 1);
    accept     = m_axis_tvalid && m_axis_tready;
    // Credit check: at most one beat in the output register plus LAT in flight/skid.
    room       = (occ_q - OW'(accept)) <= OW'(LAT);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d = ch_mask;
          num_d  = (num_samples > NW'(DEPTH)) ? NW'(DEPTH) : num_samples;
          idx_d  = '0;
          ch_d   = lo[CW-1:0];
          if (!lo[CW] || (num_samples == '0)) state_d = S_DONE;
          else                                state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (room) begin
          issue = 1'b1;
          if ({1'b0, idx_q} == (num_q - NW'(1))) begin
            idx_d = '0;
            if (nx[CW]) begin
              ch_d = nx[CW-1:0];
            end else begin
              issue_last = 1'b1;
              state_d    = S_DRAIN;
            end
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (accept && m_axis_tlast) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    occ_d = occ_q - OW'(accept) + OW'(issue);
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      ch_q    <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      occ_q   <= occ_d;
    end
  end

  // Waveform table: writes only while idle, reads only while running.
  always_ff @(posedge clk) begin
    if (tbl_we && (state_q == S_IDLE) && !busy) mem[tbl_addr] <= tbl_wdata;
    if (issue) ram_q <= mem[idx_q];
  end

  // Read-stage tag travelling alongside the RAM output.
  always_ff @(posedge clk) begin
    if (rst) r_v <= 1'b0;
    else     r_v <= issue;
    r_ch   <= ch_q;
    r_last <= issue_last;
  end

`ifdef DAC_SRC_GAIN_EN
  localparam int unsigned GW = 16;
  localparam int unsigned PW = DAC_BITS + GW;

  logic [GW-1:0]        gain_q;
  logic signed [PW-1:0] prod, scaled;
  logic [DAC_BITS-1:0]  sat_val;
  beat_t                g_pl;
  logic                 g_v;

  // Gain is frozen for the whole sweep.
  always_ff @(posedge clk) begin
    if (rst)                             gain_q <= GW'(16384);
    else if ((state_q == S_IDLE) && start) gain_q <= gain;
  end

  // Q2.14 scale with symmetric saturation to the sample range.
  always_comb begin
    prod   = PW'($signed(ram_q)) * PW'($signed(gain_q));
    scaled = prod >>> 14;
    if ((&scaled[PW-1:DAC_BITS-1]) || (~|scaled[PW-1:DAC_BITS-1]))
      sat_val = scaled[DAC_BITS-1:0];
    else if (scaled[PW-1])
      sat_val = {1'b1, {(DAC_BITS-1){1'b0}}};
    else
      sat_val = {1'b0, {(DAC_BITS-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) g_v <= 1'b0;
    else     g_v <= r_v;
    g_pl <= '{data: sat_val, ch: r_ch, last: r_last};
  end

  always_comb begin
    land_v = g_v;
    land   = g_pl;
  end
`else
  always_comb begin
    land_v = r_v;
    land   = '{data: ram_q, ch: r_ch, last: r_last};
  end
`endif

  // Output hand-off: skid entries are older than the landing beat.
  always_comb begin
    out_free = !m_axis_tvalid || m_axis_tready;
    pop      = out_free && (sk_cnt != '0);
    load     = out_free && ((sk_cnt != '0) || land_v);
    push     = land_v && !(out_free && (sk_cnt == '0));
    out_pl   = (sk_cnt != '0) ? skid[0] : land;
    push_idx = int'(sk_cnt) - int'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) sk_cnt <= '0;
    else     sk_cnt <= sk_cnt - SKW'(pop) + SKW'(push);
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      for (int i = 0; i < int'(SK) - 1; i++) skid[i] <= skid[i+1];
    end
    for (int i = 0; i < int'(SK); i++) begin
      if (push && (i == push_idx)) skid[i] <= land;
    end
  end

  // Registered AXI outputs; payload only changes when a new beat is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      active_ch     <= '0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= BITS'(out_pl.data) << (out_pl.ch * DAC_BITS);
      m_axis_tlast  <= out_pl.last;
      active_ch     <= out_pl.ch;
    end else if (accept) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Status flags follow the sequencer state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_q == S_RUN) || (state_q == S_DRAIN);
      done <= (state_q == S_DONE);
    end
  end

endmodule

// File: tb/tb_dac_stream_source.sv
// tb_dac_stream_source
//   Directed sweeps with randomized tready and table contents. Expected beats
//   are built from the table shadow: for each enabled lane in ascending order,
//   samples 0..min(num,DEPTH)-1, scaled by the gain rule, on that lane only.
module tb_dac_stream_source;

  localparam int N_DAC    = 16;
  localparam int DAC_BITS = 16;
  localparam int DEPTH    = 256;
`ifdef DAC_SRC_GAIN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         tbl_we;
  logic [7:0]   tbl_addr;
  logic [15:0]  tbl_wdata;
  logic [8:0]   num_samples;
  logic [15:0]  ch_mask;
`ifdef DAC_SRC_GAIN_EN
  logic [15:0]  gain_s;
`endif
  logic         start;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [3:0]   active_ch;
  logic         busy;
  logic         done;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] tbl_m [DEPTH];

  always #5 clk = ~clk;

  dac_stream_source dut (
    .clk           (clk),
    .rst           (rst),
    .tbl_we        (tbl_we),
    .tbl_addr      (tbl_addr),
    .tbl_wdata     (tbl_wdata),
    .num_samples   (num_samples),
    .ch_mask       (ch_mask),
`ifdef DAC_SRC_GAIN_EN
    .gain          (gain_s),
`endif
    .start         (start),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .active_ch     (active_ch),
    .busy          (busy),
    .done          (done)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Q2.14 gain with saturation; gain 16384 is an exact identity.
  function automatic int scale(input int s, input int g);
    int p;
    p = (s * g) >>> 14;
    if (p > 32767)       p = 32767;
    else if (p < -32768) p = -32768;
    return p;
  endfunction

  task automatic write_tbl(input int a, input int d);
    tbl_we = 1'b1;
    tbl_addr = 8'(a);
    tbl_wdata = 16'(d);
    tick();
    tbl_we = 1'b0;
    tbl_m[a] = 16'(d);
  endtask

  task automatic run_sweep(input logic [15:0] mask, input int nsamp, input int gval,
                           input int rdy_pct, input int rst_at, input bit co_we,
                           input int co_addr, input int co_data);
    logic [255:0] exp_w[$];
    logic [3:0]   exp_c[$];
    logic [255:0] w, held_w;
    logic         held_l;
    logic [3:0]   held_c;
    bit           stalled;
    int n_eff, total, acc, dones, done_cyc, first_v, cyc, budget;

    if (co_we) tbl_m[co_addr] = 16'(co_data);
    n_eff = (nsamp > DEPTH) ? DEPTH : nsamp;
    for (int lane = 0; lane < N_DAC; lane++) begin
      if (mask[lane]) begin
        for (int s = 0; s < n_eff; s++) begin
          w = '0;
          w[lane*DAC_BITS +: DAC_BITS] = 16'(scale(int'($signed(tbl_m[s])), gval));
          exp_w.push_back(w);
          exp_c.push_back(4'(lane));
        end
      end
    end
    total = exp_w.size();

    ch_mask = mask;
    num_samples = 9'(nsamp);
`ifdef DAC_SRC_GAIN_EN
    gain_s = 16'(gval);
`endif
    tbl_we = co_we;
    tbl_addr = 8'(co_addr);
    tbl_wdata = 16'(co_data);
    start = 1'b1;
    tick();
    start = 1'b0;
    tbl_we = 1'b0;

    cyc = 0; acc = 0; dones = 0; done_cyc = -1; first_v = -1; stalled = 0;
    held_w = '0; held_l = 1'b0; held_c = '0;
    budget = 4 * total + 20;
    while (exp_w.size() > 0 && cyc < budget) begin
      if (cyc == 1) check("busy_rise", busy, 1);
      if (done) begin dones++; if (done_cyc < 0) done_cyc = cyc; end
      if (m_axis_tvalid && first_v < 0) begin
        first_v = cyc;
        check("first_valid_latency", cyc, LAT + 1);
      end
      if (stalled) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_data", m_axis_tdata, held_w);
        check("stall_last", m_axis_tlast, held_l);
        check("stall_lane", active_ch, held_c);
      end
      if (rdy_pct == 100 && first_v >= 0) check("no_bubble", m_axis_tvalid, 1);
      if (rst_at >= 0 && acc == rst_at) break;
      tbl_we = 1'b0;
      if (cyc == 5 && busy) begin
        tbl_we = 1'b1;
        tbl_addr = 8'($urandom_range(255));
        tbl_wdata = 16'($urandom);
      end
      m_axis_tready = ($urandom_range(99) < rdy_pct);
      stalled = 0;
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          check("beat_data", m_axis_tdata, exp_w[0]);
          check("beat_lane", active_ch, exp_c[0]);
          check("beat_last", m_axis_tlast, exp_w.size() == 1);
          void'(exp_w.pop_front());
          void'(exp_c.pop_front());
          acc++;
        end else begin
          stalled = 1;
          held_w = m_axis_tdata;
          held_l = m_axis_tlast;
          held_c = active_ch;
        end
      end
      tick();
      cyc++;
    end
    tbl_we = 1'b0;

    if (rst_at >= 0) begin
      check("reset_point", acc, rst_at);
      rst = 1'b1;
      tick();
      check("midrst_tvalid", m_axis_tvalid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        check("midrst_no_done", done, 0);
        check("midrst_idle", m_axis_tvalid, 0);
      end
      m_axis_tready = 1'b1;
      return;
    end

    check("all_beats", exp_w.size(), 0);
    for (int i = 0; i < 6; i++) begin
      if (done) begin dones++; if (done_cyc < 0) done_cyc = cyc; end
      check("no_extra_valid", m_axis_tvalid, 0);
      tick();
      cyc++;
    end
    check("done_count", dones, 1);
    check("busy_fall", busy, 0);
    if (total == 0) check("empty_done_cycle", done_cyc, 1);
  endtask

  initial begin
    rst = 1'b1;
    tbl_we = 1'b0;
    tbl_addr = '0;
    tbl_wdata = '0;
    num_samples = '0;
    ch_mask = '0;
    start = 1'b0;
    m_axis_tready = 1'b1;
`ifdef DAC_SRC_GAIN_EN
    gain_s = 16'd16384;
`endif
    tick();
    tick();
    check("reset_tvalid", m_axis_tvalid, 0);
    check("reset_tdata", m_axis_tdata, 0);
    check("reset_tlast", m_axis_tlast, 0);
    check("reset_active_ch", active_ch, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 100; i++)
      write_tbl(i, int'(32767.0 * $sin(2.0 * 3.14159265358979 * i / 100.0)));
    for (int i = 100; i < DEPTH; i++)
      write_tbl(i, int'($urandom_range(65535)));

    run_sweep(16'hFFFF, 100, 16384, 100, -1, 1'b0, 0, 0);
    run_sweep(16'h8001, 4,   16384, 100, -1, 1'b0, 0, 0);
    run_sweep(16'hFFFF, 100, 16384, 50,  -1, 1'b0, 0, 0);
    run_sweep(16'h0000, 100, 16384, 100, -1, 1'b0, 0, 0);
    run_sweep(16'h0021, 300, 16384, 70,  -1, 1'b0, 0, 0);
    run_sweep(16'h0001, 0,   16384, 100, -1, 1'b0, 0, 0);
    run_sweep(16'h0004, 3,   16384, 100, -1, 1'b1, 1, 16'h1234);
    run_sweep(16'hFFFF, 100, 16384, 100, 50, 1'b0, 0, 0);
    run_sweep(16'h0003, 100, 16384, 60,  -1, 1'b0, 0, 0);

`ifdef DAC_SRC_GAIN_EN
    write_tbl(0, 32767);
    run_sweep(16'h0001, 1, 32767, 100, -1, 1'b0, 0, 0);
    write_tbl(0, 16'h8000);
    run_sweep(16'h0001, 1, -16384, 100, -1, 1'b0, 0, 0);
    write_tbl(0, 1000);
    run_sweep(16'h0001, 1, 8192, 100, -1, 1'b0, 0, 0);
    run_sweep(16'h0006, 100, 12000, 50, -1, 1'b0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
